// File: rtl/lfsr_pkg.sv
// Shared definitions for the 16-bit Fibonacci LFSR stream and its checker.
package lfsr_pkg;

  localparam int LFSR_W = 16;

  // Taps 15, 13, 12 and 10.
  localparam logic [LFSR_W-1:0] TAP_MASK = 16'hB400;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_t;

  // Successor of a word in the LFSR sequence.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] w);
    return {w[LFSR_W-2:0], ^(w & TAP_MASK)};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a clear that takes effect before a
// same-cycle increment, so clr and inc together leave the count at 1.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         nReset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count register: clear first, then increment unless already all-ones.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (nReset) begin
      count <= '0;
    end else if (clr) begin
      count <= inc ? W'(1) : '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lfsr_checker.sv
// PRBS checker for the 16-bit Fibonacci LFSR stream. Seeds its predictor
// from the first non-zero word, confirms LOCK_COUNT consecutive matches,
// then flywheels and flags every word that deviates from the prediction.
module lfsr_checker
  import lfsr_pkg::*;
#(
  parameter int LOCK_COUNT  = 8,
  parameter int UNLOCK_ERRS = 4,
  parameter int CNT_W       = 16
) (
  input  logic              clk,
  input  logic              nReset,
  input  logic              in_valid,
  input  logic [LFSR_W-1:0] in_data,
  input  logic              err_clr,
  output logic              locked,
  output logic              err_pulse,
  output logic [CNT_W-1:0]  err_count,
  output logic [1:0]        state_o
);

  localparam int RUN_W = $clog2(LOCK_COUNT + 1);
  localparam int BAD_W = $clog2(UNLOCK_ERRS + 1);
  localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(LOCK_COUNT);
  localparam logic [BAD_W-1:0] BAD_LAST = BAD_W'(UNLOCK_ERRS);

  chk_state_t        state_q, state_d;
  logic [LFSR_W-1:0] pred_q, pred_d;
  logic [RUN_W-1:0]  run_q, run_d, run_inc;
  logic [BAD_W-1:0]  bad_q, bad_d, bad_inc;
  logic              match;
  logic              locked_d;
  logic              err_hit;

  assign match   = (in_data == pred_q);
  assign run_inc = run_q + 1'b1;
  assign bad_inc = bad_q + 1'b1;
  assign state_o = state_q;

  // State register plus the registered copies of locked and err_pulse.
  always_ff @(posedge clk) begin
    if (nReset) begin
      state_q   <= SEARCH;
      pred_q    <= '0;
      run_q     <= '0;
      bad_q     <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
    end else begin
      state_q   <= state_d;
      pred_q    <= pred_d;
      run_q     <= run_d;
      bad_q     <= bad_d;
      locked    <= locked_d;
      err_pulse <= err_hit;
    end
  end

  // Next state, predictor and run/bad counters; idle cycles hold everything.
  always_comb begin
    // NOTE: defaults first so every path assigns every signal and no latch is inferred.
    state_d = state_q;
    pred_d  = pred_q;
    run_d   = run_q;
    bad_d   = bad_q;
    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          // All-zero is the LFSR lockup value and can never seed a sequence.
          if (in_data != '0) begin
            pred_d  = lfsr_next(in_data);
            run_d   = '0;
            state_d = VERIFY;
          end
        end
        VERIFY: begin
          if (match) begin
            pred_d = lfsr_next(pred_q);
            if (run_inc == RUN_LAST) begin
              state_d = LOCKED;
              run_d   = '0;
              bad_d   = '0;
            end else begin
              run_d = run_inc;
            end
          end else if (in_data != '0) begin
            pred_d = lfsr_next(in_data);
            run_d  = '0;
          end else begin
            state_d = SEARCH;
          end
        end
        LOCKED: begin
          // Flywheel: advance the prediction whether or not the word matched.
          pred_d = lfsr_next(pred_q);
          if (match) begin
            if (run_inc == RUN_LAST) begin
              run_d = '0;
              bad_d = '0;
            end else begin
              run_d = run_inc;
            end
          end else begin
            run_d = '0;
            bad_d = bad_inc;
            if (bad_inc == BAD_LAST) begin
              state_d = SEARCH;
            end
          end
        end
        default: state_d = SEARCH;
      endcase
    end
  end

  // Output decode feeding the output registers and the error counter.
  always_comb begin
    locked_d = (state_d == LOCKED);
    err_hit  = in_valid && (state_q == LOCKED) && !match;
  end

  sat_counter #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk    (clk),
    .nReset (nReset),
    .clr    (err_clr),
    .inc    (err_hit),
    .count  (err_count)
  );

endmodule

// File: tb/tb_lfsr_checker.sv
// Self-checking bench for lfsr_checker. A behavioural model written from the
// stream rules predicts every output; a second instance with a 4-bit error
// counter makes saturation reachable in a short run.
module tb_lfsr_checker;

  localparam int LOCK_COUNT  = 8;
  localparam int UNLOCK_ERRS = 4;

  logic        clk = 1'b0;
  logic        nReset;
  logic        in_valid;
  logic [15:0] in_data;
  logic        err_clr;

  logic        locked, err_pulse;
  logic [15:0] err_count;
  logic [1:0]  state_o;

  logic        locked_s, err_pulse_s;
  logic [3:0]  err_count_s;
  logic [1:0]  state_s;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  int          m_state, m_good, m_bad, m_err, m_err4;
  logic [15:0] m_expect;
  bit          m_pulse;

  // Transmit-side LFSR position.
  logic [15:0] src;

  always #5 clk = ~clk;

  lfsr_checker u_dut (
    .clk       (clk),
    .nReset    (nReset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .err_clr   (err_clr),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count),
    .state_o   (state_o)
  );

  lfsr_checker #(.CNT_W(4)) u_small (
    .clk       (clk),
    .nReset    (nReset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .err_clr   (err_clr),
    .locked    (locked_s),
    .err_pulse (err_pulse_s),
    .err_count (err_count_s),
    .state_o   (state_s)
  );

  function automatic logic [15:0] ref_next(input logic [15:0] w);
    return {w[14:0], w[15] ^ w[13] ^ w[12] ^ w[10]};
  endfunction

  function automatic logic [15:0] ref_prev(input logic [15:0] w);
    return {w[0] ^ w[14] ^ w[13] ^ w[11], w[15:1]};
  endfunction

  function automatic logic [15:0] rand_word();
    return 16'($urandom_range(1, 16'hFFFF));
  endfunction

  // Expected {state_o, locked, err_pulse, err_count} of the main instance.
  function automatic logic [19:0] exp_vec();
    return {m_state[1:0], (m_state == 2), m_pulse, m_err[15:0]};
  endfunction

  function automatic logic [7:0] exp_small();
    return {m_state[1:0], (m_state == 2), m_pulse, m_err4[3:0]};
  endfunction

  task automatic model_step(input bit rst, input bit v, input logic [15:0] d, input bit clr);
    bit hit = 1'b0;
    if (rst) begin
      m_state = 0; m_expect = '0; m_good = 0; m_bad = 0;
      m_err = 0; m_err4 = 0; m_pulse = 1'b0;
      return;
    end
    if (v) begin
      if (m_state == 0) begin
        if (d != 0) begin
          m_expect = ref_next(d); m_good = 0; m_state = 1;
        end
      end else if (m_state == 1) begin
        if (d == m_expect) begin
          m_expect = ref_next(m_expect);
          m_good++;
          if (m_good == LOCK_COUNT) begin
            m_state = 2; m_good = 0; m_bad = 0;
          end
        end else if (d != 0) begin
          m_expect = ref_next(d); m_good = 0;
        end else begin
          m_state = 0;
        end
      end else begin
        hit = (d != m_expect);
        m_expect = ref_next(m_expect);
        if (!hit) begin
          m_good++;
          if (m_good == LOCK_COUNT) begin
            m_good = 0; m_bad = 0;
          end
        end else begin
          m_good = 0;
          m_bad++;
          if (m_bad == UNLOCK_ERRS) m_state = 0;
        end
      end
    end
    m_pulse = hit;
    if (clr) begin
      m_err = 0; m_err4 = 0;
    end
    if (hit) begin
      if (m_err < 65535) m_err++;
      if (m_err4 < 15) m_err4++;
    end
  endtask

  // One clock: drive inputs, advance the model, sample 1 time unit after the edge.
  task automatic cyc(input bit rst, input bit v, input logic [15:0] d, input bit clr);
    nReset   = rst;
    in_valid = v;
    in_data  = d;
    err_clr  = clr;
    model_step(rst, v, d, clr);
    @(posedge clk);
    #1;
  endtask

  task automatic send_good();
    cyc(1'b0, 1'b1, src, 1'b0);
    src = ref_next(src);
  endtask

  task automatic send_bad(input bit clr);
    cyc(1'b0, 1'b1, src ^ rand_word(), clr);
    src = ref_next(src);
  endtask

  task automatic do_reset();
    cyc(1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic test_reset();
    nReset = 1'b1; in_valid = 1'b0; in_data = '0; err_clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, 1'b1, rand_word(), 1'b0);
      n_tests++;
      if ({state_o, locked, err_pulse, err_count} !== 20'h0) begin
        n_fail++;
        $display("FAIL reset[%0d]: got %h, expected %h", i, {state_o, locked, err_pulse, err_count}, 20'h0);
      end
    end
  endtask

  task automatic test_lock();
    do_reset();
    src = 16'hACE1;
    send_good();
    n_tests++;
    if (state_o !== 2'd1) begin
      n_fail++;
      $display("FAIL lock_first_word: state got %0d, expected 1", state_o);
    end
    for (int i = 2; i <= 9; i++) begin
      send_good();
      n_tests++;
      if ({state_o, locked, err_pulse, err_count} !== exp_vec()) begin
        n_fail++;
        $display("FAIL lock_word[%0d]: got %h, expected %h", i, {state_o, locked, err_pulse, err_count}, exp_vec());
      end
    end
    n_tests++;
    if (locked !== 1'b1 || err_count !== 16'd0) begin
      n_fail++;
      $display("FAIL lock_after_9: locked %b err_count %0d, expected 1 and 0", locked, err_count);
    end
  endtask

  task automatic test_single_error();
    do_reset();
    src = 16'hB387;
    for (int i = 0; i < 9; i++) src = ref_prev(src);
    for (int i = 0; i < 9; i++) send_good();
    cyc(1'b0, 1'b1, 16'hB386, 1'b0);
    src = ref_next(16'hB387);
    n_tests++;
    if (err_pulse !== 1'b1 || err_count !== 16'd1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL single_err: pulse %b count %0d locked %b, expected 1 1 1", err_pulse, err_count, locked);
    end
    send_good();
    n_tests++;
    if (err_pulse !== 1'b0 || err_count !== 16'd1 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL single_err_resume: pulse %b count %0d locked %b, expected 0 1 1", err_pulse, err_count, locked);
    end
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < int'($urandom_range(8, 12)); i++) send_good();
      send_bad(1'b0);
      n_tests++;
      if ({state_o, locked, err_pulse, err_count} !== exp_vec()) begin
        n_fail++;
        $display("FAIL single_err_rand[%0d]: got %h, expected %h", k, {state_o, locked, err_pulse, err_count}, exp_vec());
      end
    end
  endtask

  task automatic test_unlock();
    do_reset();
    src = rand_word();
    for (int i = 0; i < 9; i++) send_good();
    for (int k = 0; k < 4; k++) begin
      send_bad(1'b0);
      if (k < 3) begin
        for (int i = 0; i < int'($urandom_range(0, 2)); i++) send_good();
        n_tests++;
        if (locked !== 1'b1) begin
          n_fail++;
          $display("FAIL unlock_early[%0d]: locked got %b, expected 1", k, locked);
        end
      end
    end
    n_tests++;
    if (locked !== 1'b0 || state_o !== 2'd0 || err_count !== 16'd4 || err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL unlock: locked %b state %0d count %0d pulse %b, expected 0 0 4 1",
               locked, state_o, err_count, err_pulse);
    end
    for (int i = 1; i <= 9; i++) begin
      send_good();
      n_tests++;
      if ({state_o, locked, err_pulse, err_count} !== exp_vec()) begin
        n_fail++;
        $display("FAIL relock[%0d]: got %h, expected %h", i, {state_o, locked, err_pulse, err_count}, exp_vec());
      end
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL relock_final: locked got %b, expected 1", locked);
    end
  endtask

  task automatic test_zero_and_gaps();
    int nvalid = 0;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      cyc(1'b0, 1'b1, 16'h0000, 1'b0);
      n_tests++;
      if (state_o !== 2'd0 || locked !== 1'b0 || err_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL zero_words[%0d]: state %0d locked %b pulse %b, expected 0 0 0", i, state_o, locked, err_pulse);
      end
    end
    src = rand_word();
    while (nvalid < 9) begin
      send_good();
      nvalid++;
      cyc(1'b0, 1'b0, rand_word(), 1'b0);
      n_tests++;
      if ({state_o, locked, err_pulse, err_count} !== exp_vec()) begin
        n_fail++;
        $display("FAIL gaps[%0d]: got %h, expected %h", nvalid, {state_o, locked, err_pulse, err_count}, exp_vec());
      end
    end
    n_tests++;
    if (locked !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_lock: locked got %b, expected 1", locked);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    src = rand_word();
    for (int i = 0; i < 9; i++) send_good();
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 3; i++) send_bad(1'b0);
      for (int i = 0; i < 8; i++) send_good();
      n_tests++;
      if ({state_s, locked_s, err_pulse_s, err_count_s} !== exp_small()) begin
        n_fail++;
        $display("FAIL sat_round[%0d]: got %h, expected %h", r, {state_s, locked_s, err_pulse_s, err_count_s}, exp_small());
      end
    end
    send_bad(1'b0);
    n_tests++;
    if (err_count_s !== 4'hF || err_count !== 16'd19) begin
      n_fail++;
      $display("FAIL saturate: small %h main %0d, expected f and 19", err_count_s, err_count);
    end
    send_bad(1'b1);
    n_tests++;
    if (err_count_s !== 4'd1 || err_count !== 16'd1 || err_pulse !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_with_inc: small %0d main %0d pulse %b, expected 1 1 1", err_count_s, err_count, err_pulse);
    end
    cyc(1'b0, 1'b0, rand_word(), 1'b1);
    n_tests++;
    if (err_count_s !== 4'd0 || err_count !== 16'd0 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL clr_alone: small %0d main %0d locked %b, expected 0 0 1", err_count_s, err_count, locked);
    end
  endtask

  task automatic test_reset_mid_lock();
    do_reset();
    src = rand_word();
    for (int i = 0; i < 9; i++) send_good();
    for (int i = 0; i < 3; i++) send_bad(1'b0);
    n_tests++;
    if (err_count !== 16'd3 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset: count %0d locked %b, expected 3 1", err_count, locked);
    end
    cyc(1'b1, 1'b1, src, 1'b0);
    n_tests++;
    if (state_o !== 2'd0 || locked !== 1'b0 || err_count !== 16'd0 || err_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_lock: state %0d locked %b count %0d pulse %b, expected 0 0 0 0",
               state_o, locked, err_count, err_pulse);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    bit          v;
    do_reset();
    src = rand_word();
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = rand_word();
      if (v) begin
        case ($urandom_range(0, 63))
          0:       d = 16'h0000;
          1, 2, 3: d = src ^ rand_word();
          4:       src = d;
          default: d = src;
        endcase
        src = ref_next(src);
      end
      cyc(1'b0, v, d, ($urandom_range(0, 31) == 0));
      n_tests++;
      if ({state_o, locked, err_pulse, err_count} !== exp_vec()) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %h, expected %h", i, {state_o, locked, err_pulse, err_count}, exp_vec());
      end
    end
  endtask

  initial begin
    nReset   = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    err_clr  = 1'b0;
    test_reset();
    test_lock();
    test_single_error();
    test_unlock();
    test_zero_and_gaps();
    test_saturation();
    test_reset_mid_lock();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
